alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 39 +++
 rtl/alu_unit.sv | 143 ++++++++++++++
 tb/tb_alu_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: the 4-bit operation select type
// and the named operation codes.
//
// Bit 3 of a code selects subtract mode in the shared adder: B is inverted and
// the carry-in is 1. SUB, SLT and SLTU rely on this bit.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND  = 4'b0000;
    localparam alu_ctrl_t ALU_OR   = 4'b0001;
    localparam alu_ctrl_t ALU_ADD  = 4'b0010;
    localparam alu_ctrl_t ALU_XOR  = 4'b0011;
    localparam alu_ctrl_t ALU_NOR  = 4'b0100;
    localparam alu_ctrl_t ALU_SLL  = 4'b0101;
    localparam alu_ctrl_t ALU_SRL  = 4'b0110;
    localparam alu_ctrl_t ALU_SRA  = 4'b0111;
    localparam alu_ctrl_t ALU_SUB  = 4'b1010;
    localparam alu_ctrl_t ALU_SLT  = 4'b1011;
    localparam alu_ctrl_t ALU_SLTU = 4'b1100;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Barrel shifter for the ALU shift operations. A shift amount wider than the
// operand is not possible, because shamt is only $clog2(WIDTH) bits wide.
//
// Ports:
//   a      - value to shift (operand A)
//   shamt  - shift amount (low bits of operand B)
//   op     - ALU operation code; only SLL/SRL/SRA produce a non-zero result
//   result - shifted value, zero for every other op
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  alu_ctrl_t        op,
    output logic [WIDTH-1:0] result
);

    logic signed [WIDTH-1:0] a_signed;

    assign a_signed = a;

    always_comb begin
        result = '0;
        case (op)
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            // Arithmetic shift replicates the sign bit a[WIDTH-1].
            ALU_SRA: result = a_signed >>> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Integer ALU for the execute stage. The result and zero flag are purely
// combinational; they feed branch resolution and forwarding. A registered copy
// of both is kept for the EX/MEM boundary.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears only out_q/zero_q)
//   A, B   - operands (rs, rt/immediate)
//   ctrl   - operation select (see alu_pkg)
//   en     - load enable for the registered outputs
//   out    - combinational result
//   zero   - combinational, 1 when out == 0
//   out_q  - registered result
//   zero_q - registered zero flag
//
// Optional feature (macro ALU_OVERFLOW_EN):
//   ovf    - combinational signed overflow, valid for ADD and SUB only
//   ovf_q  - registered ovf, reset value 0
//
// Load semantics: en is a plain load qualifier, not a handshake. On a rising
// clk edge with en=1 the registered outputs take the current combinational
// values; with en=0 they hold. There is no back-pressure.
// -----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ctrl,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] out_q,
    output logic             zero_q
`ifdef ALU_OVERFLOW_EN
   ,output logic             ovf,
    output logic             ovf_q
`endif
);

    localparam int SHW = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // Shared adder. ctrl[3] puts it in subtract mode (A + ~B + 1). SLTU
    // shares this path, so its borrow comes from the same carry-out.
    // ------------------------------------------------------------------
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf_raw;
    logic             slt_bit;
    logic             sltu_bit;

    assign sub_mode = ctrl[3];
    assign b_eff    = sub_mode ? ~B : B;
    assign sum_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];

    // Signed overflow: the addend signs agree but the sum sign differs.
    assign ovf_raw  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    // Correcting the sum sign with the overflow bit keeps SLT exact at the
    // extremes, e.g. 0x80000000 < 1 and 0x7FFFFFFF < -1.
    assign slt_bit  = sum[WIDTH-1] ^ ovf_raw;

    // A - B produces a carry-out exactly when A >= B (unsigned).
    assign sltu_bit = ~carry;

    // ------------------------------------------------------------------
    // Shifter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shift_res;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .a      (A),
        .shamt  (B[SHW-1:0]),
        .op     (ctrl),
        .result (shift_res)
    );

    // ------------------------------------------------------------------
    // Result mux. Undefined codes yield 0, so zero is 1 for them.
    // ------------------------------------------------------------------
    always_comb begin
        out = '0;
        case (ctrl)
            ALU_AND:  out = A & B;
            ALU_OR:   out = A | B;
            ALU_ADD:  out = sum;
            ALU_XOR:  out = A ^ B;
            ALU_NOR:  out = ~(A | B);
            ALU_SLL:  out = shift_res;
            ALU_SRL:  out = shift_res;
            ALU_SRA:  out = shift_res;
            ALU_SUB:  out = sum;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_SLTU: out = {{(WIDTH-1){1'b0}}, sltu_bit};
            default:  out = '0;
        endcase
    end

    assign zero = ~|out;

`ifdef ALU_OVERFLOW_EN
    assign ovf = ovf_raw && ((ctrl == ALU_ADD) || (ctrl == ALU_SUB));
`endif

    // ------------------------------------------------------------------
    // EX/MEM registered copy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else if (en) begin
            out_q  <= out;
            zero_q <= zero;
        end
    end

`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Directed and random stimulus for alu_unit. Expected combinational and
// registered values are pushed to queues when inputs are driven and popped
// when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 32;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic [3:0]   ctrl;
    logic         en;
    logic [W-1:0] out, out_q;
    logic         zero, zero_q;
`ifdef ALU_OVERFLOW_EN
    logic         ovf, ovf_q;
`endif

    always #5 clk = ~clk;

    alu_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .ctrl   (ctrl),
        .en     (en),
        .out    (out),
        .zero   (zero),
        .out_q  (out_q),
        .zero_q (zero_q)
`ifdef ALU_OVERFLOW_EN
       ,.ovf    (ovf),
        .ovf_q  (ovf_q)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [W:0] exp_q[$];      // {zero, out} expected on the comb path
    logic [W:0] reg_exp_q[$];  // {zero_q, out_q} expected after the edge
    logic [W:0] model_q;       // bench copy of the registered state
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model written from the operation definitions.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        sa = a;
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0100: return ~(a | b);
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return sa >>> b[4:0];
            4'b1010: return a - b;
            4'b1011: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return (a < b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Driver: drive at negedge, check comb path, then registered path.
    // ------------------------------------------------------------------
    task automatic do_step(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic e, input logic [W-1:0] exp_out);
        logic [W:0] got;
        @(negedge clk);
        A = a; B = b; ctrl = c; en = e;
        exp_q.push_back({(exp_out == '0), exp_out});
        if (e) model_q = {(exp_out == '0), exp_out};
        reg_exp_q.push_back(model_q);
        #1;
        got = exp_q.pop_front();
        check({tag, ".out"},  {1'b0, out},  {1'b0, got[W-1:0]});
        check({tag, ".zero"}, {{W{1'b0}}, zero}, {{W{1'b0}}, got[W]});
        @(posedge clk);
        #1;
        got = reg_exp_q.pop_front();
        check({tag, ".out_q"},  {1'b0, out_q}, {1'b0, got[W-1:0]});
        check({tag, ".zero_q"}, {{W{1'b0}}, zero_q}, {{W{1'b0}}, got[W]});
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0]   rc;
        logic [W-1:0] ra, rb;
        logic         re;

        rst_n = 1'b1; en = 1'b1; A = '0; B = '0; ctrl = ALU_AND;
        model_q = {1'b1, {W{1'b0}}};

        // Reset asserted with en high: registered outputs cleared.
        #2 rst_n = 1'b0;
        #1;
        check("rst.out",    {1'b0, out},    {1'b0, 32'h0});
        check("rst.zero",   {{W{1'b0}}, zero},   {{W{1'b0}}, 1'b1});
        check("rst.out_q",  {1'b0, out_q},  {1'b0, 32'h0});
        check("rst.zero_q", {{W{1'b0}}, zero_q}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #1;
        check("rst_edge.out_q", {1'b0, out_q}, {1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.out_q",  {1'b0, out_q},  {1'b0, 32'h0});
        check("rel.zero_q", {{W{1'b0}}, zero_q}, {{W{1'b0}}, 1'b1});

        // Directed operations
        do_step("add_0_ff",    ALU_ADD,  32'h0,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);
        do_step("and_0_ff",    ALU_AND,  32'h0,        32'hFFFFFFFF, 1'b1, 32'h0);
        do_step("or_ff",       ALU_OR,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);
        do_step("sub_eq",      ALU_SUB,  32'h1,        32'h1,        1'b1, 32'h0);
        do_step("slt_eq",      ALU_SLT,  32'h1,        32'h1,        1'b1, 32'h0);
        do_step("slt_0_1",     ALU_SLT,  32'h0,        32'h1,        1'b1, 32'h1);
        do_step("slt_min",     ALU_SLT,  32'h80000000, 32'h1,        1'b1, 32'h1);
        do_step("sltu_min",    ALU_SLTU, 32'h80000000, 32'h1,        1'b1, 32'h0);
        do_step("slt_max_m1",  ALU_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0);
        do_step("sltu_1_min",  ALU_SLTU, 32'h1,        32'h80000000, 1'b1, 32'h1);
        do_step("sub_wrap",    ALU_SUB,  32'h0,        32'h1,        1'b1, 32'hFFFFFFFF);
        do_step("add_ovf",     ALU_ADD,  32'h7FFFFFFF, 32'h1,        1'b1, 32'h80000000);
        do_step("xor",         ALU_XOR,  32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 32'hAAAAAAAA);
        do_step("nor",         ALU_NOR,  32'hF0F0F0F0, 32'h0000FFFF, 1'b1, 32'h0F0F0000);
        do_step("sll",         ALU_SLL,  32'h80000001, 32'h4,        1'b1, 32'h00000010);
        do_step("sll_hi_b",    ALU_SLL,  32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h80000000);
        do_step("srl",         ALU_SRL,  32'h80000001, 32'h4,        1'b1, 32'h08000000);

        // Enable low: combinational path follows, registered copy holds.
        do_step("sra_hold",    ALU_SRA,  32'h80000001, 32'h4,        1'b0, 32'hF8000000);
        do_step("undef_hold",  4'b1111,  32'h80000001, 32'h4,        1'b0, 32'h0);

        // Async reset pulse between edges, no clock edge involved.
        @(negedge clk);
        ctrl = ALU_SRA; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("apulse.out_q",  {1'b0, out_q}, {1'b0, 32'h0});
        check("apulse.zero_q", {{W{1'b0}}, zero_q}, {{W{1'b0}}, 1'b1});
        check("apulse.out",    {1'b0, out},   {1'b0, 32'hF8000000});
        #1 rst_n = 1'b1;
        model_q = {1'b1, {W{1'b0}}};

        do_step("post_rst_hold", ALU_OR,  32'h1,        32'h2,   1'b0, 32'h3);
        do_step("sra_load",      ALU_SRA, 32'h80000001, 32'h4,   1'b1, 32'hF8000000);
        do_step("undef_load",    4'b1111, 32'h12345678, 32'h9,   1'b1, 32'h0);
        do_step("undef_8",       4'b1000, 32'hFFFFFFFF, 32'h1,   1'b1, 32'h0);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            re = 1'($urandom_range(0, 1));
            do_step($sformatf("rand%0d", i), rc, ra, rb, re, ref_alu(rc, ra, rb));
        end

`ifdef ALU_OVERFLOW_EN
        @(negedge clk);
        A = 32'h7FFFFFFF; B = 32'h1; ctrl = ALU_ADD; en = 1'b1;
        #1 check("ovf_add", {{W{1'b0}}, ovf}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #1;
        check("ovf_q_add", {{W{1'b0}}, ovf_q}, {{W{1'b0}}, 1'b1});
        @(negedge clk);
        A = 32'h80000000; B = 32'h1; ctrl = ALU_SUB;
        #1 check("ovf_sub", {{W{1'b0}}, ovf}, {{W{1'b0}}, 1'b1});
        @(negedge clk);
        A = 32'h7FFFFFFF; B = 32'h1; ctrl = ALU_SLT;
        #1 check("ovf_slt", {{W{1'b0}}, ovf}, {{W{1'b0}}, 1'b0});
        @(negedge clk);
        A = 32'h5; B = 32'h3; ctrl = ALU_SUB;
        #1 check("ovf_sub_ok", {{W{1'b0}}, ovf}, {{W{1'b0}}, 1'b0});
        @(posedge clk); #1;
        check("ovf_q_clr", {{W{1'b0}}, ovf_q}, {{W{1'b0}}, 1'b0});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
